// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit MULT/MULTU/DIV/DIVU with HI/LO (ports: clk, rst_n, start, op, A, B, wr_hi, wr_lo, wr_data -> busy, done, div_by_zero, HI, LO)
module mult_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t      state;
  logic [4:0]  cnt;
  logic        is_div, sa, sb, bz;
  logic [31:0] a, b;
  logic [63:0] acc;
  logic [32:0] rem;
  logic [31:0] a_mag, b_mag, quo, rmd, a_orig;
  logic [32:0] msum, shl;
  logic [33:0] diff;
  logic [63:0] prod;
  always_comb begin
    a_mag  = (~op[0] & A[31]) ? -A : A;
    b_mag  = (~op[0] & B[31]) ? -B : B;
    msum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a} : 33'd0);
    shl    = {rem[31:0], acc[31]};
    diff   = {1'b0, shl} - {2'b00, b};
    prod   = (sa ^ sb) ? -acc : acc;
    quo    = (sa ^ sb) ? -acc[31:0] : acc[31:0];
    rmd    = sa ? -rem[31:0] : rem[31:0];
    a_orig = sa ? -a : a;
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 5'd0;
      is_div      <= 1'b0;
      sa          <= 1'b0;
      sb          <= 1'b0;
      bz          <= 1'b0;
      a           <= '0;
      b           <= '0;
      acc         <= '0;
      rem         <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      HI          <= '0;
      LO          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state  <= RUN;
          cnt    <= 5'd0;
          is_div <= op[1];
          sa     <= ~op[0] & A[31];
          sb     <= ~op[0] & B[31];
          bz     <= op[1] & (B == 32'd0);
          a      <= a_mag;
          b      <= b_mag;
          acc    <= {32'd0, op[1] ? a_mag : b_mag};
          rem    <= '0;
        end else begin
          if (wr_hi) HI <= wr_data;
          if (wr_lo) LO <= wr_data;
        end
        RUN: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
          if (is_div) begin
            acc[31:0] <= {acc[30:0], ~diff[33]};
            rem       <= diff[33] ? shl : diff[32:0];
          end else
            acc <= {msum, acc[31:1]};
        end
        FIX: begin
          state       <= IDLE;
          done        <= 1'b1;
          div_by_zero <= bz;
          HI          <= bz ? a_orig : is_div ? rmd : prod[63:32];
          LO          <= bz ? 32'hFFFF_FFFF : is_div ? quo : prod[31:0];
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: table-driven and scoreboard bench for mult_div_unit
module tb_mult_div_unit;
  logic clk = 0, rst_n = 0, start = 0, wr_hi = 0, wr_lo = 0;
  logic busy, done, div_by_zero;
  logic [1:0] op = 0;
  logic [31:0] A = 0, B = 0, wr_data = 0, HI, LO;
  typedef struct {logic [31:0] hi, lo; logic dz;} exp_t;
  typedef struct {logic [1:0] op; logic [31:0] a, b, hi, lo; logic dz;} vec_t;
  exp_t sb[$];
  exp_t e;
  vec_t tv[9];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mult_div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .HI(HI), .LO(LO)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) if (rst_n && done) begin
    if (sb.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
    else begin
      e = sb.pop_front();
      chk("HI", HI, e.hi);
      chk("LO", LO, e.lo);
      chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
    end
  end
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz, input bit disturb);
    logic [31:0] hi0 = HI;
    int busy_n = 1;
    int lat = 0;
    bit got = 0;
    start = 1; op = o; A = a; B = b;
    sb.push_back('{ehi, elo, edz});
    @(posedge clk); #1;
    start = 0; wr_hi = 0; wr_lo = 0;
    A = $urandom; B = $urandom; op = 2'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("hi_hold", HI, hi0);
    for (int k = 1; k <= 40 && !got; k++) begin
      if (disturb && k == 5) begin
        start = 1; op = 2'b01; A = 5; B = 5; wr_hi = 1; wr_data = 32'h1234;
      end
      @(posedge clk); #1;
      start = 0; wr_hi = 0;
      if (done) begin got = 1; lat = k; end
      else if (busy) busy_n++;
    end
    chk("latency", 32'(lat), 32'd33);
    chk("busy_cycles", 32'(busy_n), 32'd33);
    chk("busy_in_done", 32'(busy), 32'd0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] ra, rb;
    logic [63:0] p;
    bit seen;
    tv[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    tv[1] = '{2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    tv[2] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    tv[3] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    tv[4] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    tv[5] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    tv[6] = '{2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
    tv[7] = '{2'b11, 32'd0,        32'd0,        32'd0,        32'hFFFFFFFF, 1'b1};
    tv[8] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz", 32'(div_by_zero), 32'd0);
    chk("rst_HI", HI, 32'd0);
    chk("rst_LO", LO, 32'd0);
    rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) run_op(tv[i].op, tv[i].a, tv[i].b, tv[i].hi, tv[i].lo, tv[i].dz, 0);
    run_op(2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 0);
    wr_hi = 1; wr_data = 32'd77;
    @(posedge clk); #1;
    wr_hi = 0;
    chk("mthi_HI", HI, 32'd77);
    chk("mthi_keeps_dz", 32'(div_by_zero), 32'd1);
    run_op(2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 0);
    run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1);
    wr_lo = 1; wr_data = 32'hABCD;
    @(posedge clk); #1;
    wr_lo = 0;
    chk("mtlo_LO", LO, 32'hABCD);
    chk("mtlo_HI_kept", HI, 32'd2);
    wr_hi = 1; wr_lo = 1; wr_data = 32'h5A5A;
    @(posedge clk); #1;
    wr_hi = 0; wr_lo = 0;
    chk("mthilo_HI", HI, 32'h5A5A);
    chk("mthilo_LO", LO, 32'h5A5A);
    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom;
      if (i % 3 == 0) begin
        p = 64'(ra) * 64'(rb);
        run_op(2'b01, ra, rb, p[63:32], p[31:0], 1'b0, 0);
      end else if (i % 3 == 1) begin
        if (rb == 0) rb = 1;
        run_op(2'b11, ra, rb, ra % rb, ra / rb, 1'b0, 0);
      end else begin
        p = $signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb});
        run_op(2'b00, ra, rb, p[63:32], p[31:0], 1'b0, 0);
      end
    end
    wr_hi = 1; wr_data = 32'hDEAD;
    run_op(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 0);
    run_op(2'b11, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, 0);
    start = 1; op = 2'b11; A = 32'd1000; B = 32'd3;
    @(posedge clk); #1;
    start = 0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_HI", HI, 32'd0);
    chk("abort_LO", LO, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= done;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    run_op(2'b11, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, 0);
    @(posedge clk); #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
